sqrt_newton_iter: RTL and testbench
===================================

SQRT_NEWTON_ITER -- requirements
Module: sqrt_newton_iter

Interface
REQ-001 The block SHALL have parameter Width, default 32, giving the bit width of x, y0 and yo (even, 4..64).
REQ-002 The block SHALL have parameter MaxIter, default 16, giving the maximum Newton iterations per request (1..255).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rstn  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port req  input  1  start request, sampled high in IDLE.
REQ-006 The block SHALL have port x  input  Width  radicand, captured at start.
REQ-007 The block SHALL have port y0  input  Width  initial estimate from the upstream initial-value stage, captured at start.
REQ-008 The block SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 The block SHALL have port fin  output  1  one-cycle pulse marking yo valid.
REQ-010 The block SHALL have port yo  output  Width  floor(sqrt(x)), held until the next start.
REQ-011 The block SHALL have port ovf  output  1  high with fin when MaxIter was exhausted before convergence.

Function
REQ-012 The FSM SHALL have states IDLE, DIV, UPDATE and DONE.
REQ-013 In IDLE with req=1, the block SHALL capture x into X and y0 into Y, where y0=0 is replaced by 1; it SHALL clear the iteration count n and go to DIV, or go to DONE with Y=0 when x=0.
REQ-014 DIV SHALL perform a restoring shift-subtract division X/Y, one quotient bit per cycle, for exactly Width cycles, yielding Q; it SHALL then go to UPDATE.
REQ-015 UPDATE SHALL compute S=Y+Q in Width+1 bits without truncation and Yn=S>>1.
REQ-016 In UPDATE, if n=0 or Yn<Y, the block SHALL load Yn into Y and increment n; it SHALL return to DIV when n<MaxIter after the increment, otherwise set ovf and go to DONE.
REQ-017 In UPDATE, if n>0 and Yn>=Y, the block SHALL leave Y unchanged and go to DONE.
REQ-018 DONE SHALL drive yo=Y and fin=1 for exactly one cycle, then return to IDLE.
REQ-019 Latency from the req-sampling edge to fin high SHALL be 1+k*(Width+1) cycles for k completed UPDATE passes, and 1 cycle for x=0.
REQ-020 A req arriving while busy=1 SHALL be ignored; it SHALL not be queued.
REQ-021 A req held high through DONE SHALL start a new operation on the first IDLE cycle.
REQ-022 x and y0 changing after capture SHALL not affect the result.
REQ-023 ovf SHALL clear at the next start.

Reset
REQ-024 While rstn=0 at a clock edge, the block SHALL enter IDLE and clear busy, fin, ovf, yo, n and all datapath registers.
REQ-025 Reset asserted in any state, including mid-DIV, SHALL abort the operation and produce no fin pulse.
REQ-026 The first req SHALL be accepted on the first edge after rstn returns high.

Configuration
REQ-027 With macro SQRT_NEWTON_ITERCNT_EN defined, the block SHALL add output iter_cnt[7:0], equal to n and latched at DONE, holding the same value as yo and cleared by reset.
REQ-028 Without SQRT_NEWTON_ITERCNT_EN, the port and its register SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Width=32, x=0, y0=5, req pulse -> fin one cycle later, yo=0, ovf=0.
REQ-030 x=16, y0=4 -> yo=4, 2 UPDATE passes, fin at 1+2*33=67 cycles, iter_cnt=1 when SQRT_NEWTON_ITERCNT_EN is defined.
REQ-031 x=0xFFFFFFFF, y0=0x10000 -> yo=0xFFFF, ovf=0; x=1000000, y0=1024 -> yo=1000.
REQ-032 x=10, y0=0 (substituted 1) -> yo=3 via the sequence 5,3; MaxIter=1 with x=10, y0=0 -> ovf=1, yo=5.
REQ-033 rstn=0 during the 10th DIV cycle -> IDLE, yo=0, no fin; a subsequent req with x=81, y0=16 -> yo=9.
REQ-034 A second req pulse while busy -> ignored; exactly one fin and an unchanged result.

Source files
------------

// File: rtl/sqrt_newton_iter.sv
// sqrt_newton_iter: integer square root by Newton iteration, yo = floor(sqrt(x)).
//   clk, rstn (sync, active-low), req/x/y0 start a run from IDLE; busy high outside IDLE,
//   fin pulses one cycle with yo valid, ovf set with fin when MaxIter ran out first.
//   Optional output iter_cnt (iteration count) when SQRT_NEWTON_ITERCNT_EN is defined.
module sqrt_newton_iter #(
  parameter int Width   = 32,
  parameter int MaxIter = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req,
  input  logic [Width-1:0] x,
  input  logic [Width-1:0] y0,
  output logic             busy,
  output logic             fin,
  output logic [Width-1:0] yo,
  output logic             ovf
`ifdef SQRT_NEWTON_ITERCNT_EN
  ,
  output logic [7:0]       iter_cnt
`endif
);
  localparam logic [1:0] IDLE = 2'd0, DIV = 2'd1, UPDATE = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(Width);
  localparam logic [7:0] MI = 8'(MaxIter);
  logic [1:0] state;
  logic [Width-1:0] xr, yr, qr, rem, yn;
  logic [CW-1:0] cnt;
  logic [7:0] n, n1;
  logic [Width:0] rem_sh, diff, s;
  logic ge;
  // qr starts as the dividend and shifts its MSB into the remainder while
  // quotient bits shift in at the bottom; after Width cycles qr holds X/Y.
  always_comb begin
    rem_sh = {rem, qr[Width-1]};
    diff   = rem_sh - {1'b0, yr};
    ge     = rem_sh >= {1'b0, yr};
    s      = {1'b0, yr} + {1'b0, qr};
    yn     = s[Width:1];
    n1     = n + 8'd1;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      xr    <= '0;
      yr    <= '0;
      qr    <= '0;
      rem   <= '0;
      cnt   <= '0;
      n     <= '0;
      fin   <= 1'b0;
      yo    <= '0;
      ovf   <= 1'b0;
`ifdef SQRT_NEWTON_ITERCNT_EN
      iter_cnt <= '0;
`endif
    end else begin
      fin <= 1'b0;
      case (state)
        IDLE: if (req) begin
          xr    <= x;
          yr    <= (x == '0) ? '0 : ((y0 == '0) ? Width'(1) : y0);
          qr    <= x;
          rem   <= '0;
          cnt   <= '0;
          n     <= 8'd0;
          ovf   <= 1'b0;
          state <= (x == '0) ? DONE : DIV;
        end
        DIV: begin
          rem <= ge ? diff[Width-1:0] : rem_sh[Width-1:0];
          qr  <= {qr[Width-2:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(Width - 1)) state <= UPDATE;
        end
        UPDATE: begin
          // The first pass always moves; afterwards only a strict decrease continues.
          if (n == 8'd0 || yn < yr) begin
            yr  <= yn;
            n   <= n1;
            qr  <= xr;
            rem <= '0;
            cnt <= '0;
            if (n1 < MI) state <= DIV;
            else begin
              ovf   <= 1'b1;
              state <= DONE;
            end
          end else state <= DONE;
        end
        default: begin
          fin   <= 1'b1;
          yo    <= yr;
`ifdef SQRT_NEWTON_ITERCNT_EN
          iter_cnt <= n;
`endif
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sqrt_newton_iter.sv
// tb_sqrt_newton_iter: directed + random checks of sqrt_newton_iter against a Newton-rule model.
module tb_sqrt_newton_iter;
  logic clk = 1'b0, rstn = 1'b0, req = 1'b0, req1 = 1'b0;
  logic [31:0] x = '0, y0 = '0;
  logic busy, fin, ovf, busy1, fin1, ovf1;
  logic [31:0] yo, yo1;
  int checks = 0, failures = 0;
`ifdef SQRT_NEWTON_ITERCNT_EN
  logic [7:0] iter_cnt, iter_cnt1;
`endif

  always #5 clk = ~clk;

  sqrt_newton_iter #(.Width(32), .MaxIter(16)) dut (
    .clk(clk), .rstn(rstn), .req(req), .x(x), .y0(y0),
    .busy(busy), .fin(fin), .yo(yo), .ovf(ovf)
`ifdef SQRT_NEWTON_ITERCNT_EN
    , .iter_cnt(iter_cnt)
`endif
  );

  sqrt_newton_iter #(.Width(32), .MaxIter(1)) dut1 (
    .clk(clk), .rstn(rstn), .req(req1), .x(x), .y0(y0),
    .busy(busy1), .fin(fin1), .yo(yo1), .ovf(ovf1)
`ifdef SQRT_NEWTON_ITERCNT_EN
    , .iter_cnt(iter_cnt1)
`endif
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Integer Newton as described: y <- (y + x/y)/2, first pass always taken,
  // stop when no strict decrease, overflow once mi iterations are used.
  task automatic model(input longint xx, input longint yy0, input int mi,
                       output longint ry, output bit rov, output int k, output int n);
    longint y, yn;
    bit stop;
    ry = 0; rov = 0; k = 0; n = 0;
    if (xx != 0) begin
      y = (yy0 == 0) ? 1 : yy0;
      stop = 0;
      while (!stop) begin
        yn = (y + xx / y) / 2;
        k++;
        if (n == 0 || yn < y) begin
          y = yn;
          n++;
          if (n >= mi) begin rov = 1; stop = 1; end
        end else stop = 1;
      end
      ry = y;
    end
  endtask

  function automatic longint isqrt(input longint xx);
    longint r = 0, t;
    for (int b = 16; b >= 0; b--) begin
      t = r | (longint'(1) << b);
      if (t * t <= xx) r = t;
    end
    return r;
  endfunction

  task automatic run(input bit sel, input logic [31:0] xi, input logic [31:0] yi,
                     output int lat, output logic [31:0] ryo, output logic rovf,
                     output logic [7:0] rit);
    bit got = 0;
    @(negedge clk);
    x = xi; y0 = yi;
    if (sel) req1 = 1'b1; else req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; req1 = 1'b0;
    x = $urandom; y0 = $urandom;
    check("busy_after_start", sel ? busy1 : busy, 1);
    lat = 0;
    for (int c = 1; c <= 3000 && !got; c++) begin
      @(posedge clk); #1;
      if (sel ? fin1 : fin) begin got = 1; lat = c; end
    end
    if (!got) check("fin_timeout", 0, 1);
    ryo  = sel ? yo1 : yo;
    rovf = sel ? ovf1 : ovf;
    rit  = 8'd0;
`ifdef SQRT_NEWTON_ITERCNT_EN
    rit = sel ? iter_cnt1 : iter_cnt;
`endif
    check("busy_at_fin", sel ? busy1 : busy, 0);
    @(posedge clk); #1;
    check("fin_one_cycle", sel ? fin1 : fin, 0);
  endtask

  task automatic do_test(input bit sel, input logic [31:0] xi, input logic [31:0] yi);
    int lat, k, n;
    logic [31:0] ryo;
    logic rovf;
    logic [7:0] rit;
    longint ey;
    bit eov;
    model(xi, yi, sel ? 1 : 16, ey, eov, k, n);
    run(sel, xi, yi, lat, ryo, rovf, rit);
    check("yo", ryo, ey);
    check("ovf", rovf, eov);
    check("latency", lat, xi == 0 ? 1 : 1 + k * 33);
    if (!eov) check("yo_isqrt", ryo, isqrt(xi));
`ifdef SQRT_NEWTON_ITERCNT_EN
    check("iter_cnt", rit, n);
`endif
  endtask

  initial begin
    int fins;
    bit got;
    logic [31:0] first_yo;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_fin", fin, 0);
    check("rst_ovf", ovf, 0);
    check("rst_yo", yo, 0);
    @(negedge clk); rstn = 1'b1;

    do_test(0, 32'd0, 32'd5);
    do_test(0, 32'd16, 32'd4);
    do_test(0, 32'hFFFF_FFFF, 32'h0001_0000);
    do_test(0, 32'd1000000, 32'd1024);
    do_test(0, 32'd10, 32'd0);
    do_test(0, 32'd1, 32'd0);
    do_test(0, 32'd3, 32'hFFFF_FFFF);
    do_test(1, 32'd10, 32'd0);
    check("maxiter1_yo", yo1, 5);
    check("maxiter1_ovf", ovf1, 1);
    do_test(1, 32'd16, 32'd4);
    do_test(0, 32'd12, 32'd0);

    for (int i = 0; i < 30; i++) begin
      logic [31:0] rx, ry;
      rx = $urandom >> $urandom_range(0, 31);
      ry = $urandom >> $urandom_range(0, 31);
      do_test(0, rx, ry);
    end

    // Request while busy must be ignored: exactly one fin with the first result.
    @(negedge clk); x = 32'd1000000; y0 = 32'd1024; req = 1'b1;
    @(negedge clk); req = 1'b0;
    repeat (5) @(negedge clk);
    x = 32'd55; y0 = 32'd7; req = 1'b1;
    @(negedge clk); req = 1'b0;
    fins = 0; first_yo = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (fin) begin
        fins++;
        if (fins == 1) first_yo = yo;
      end
    end
    check("busy_ignore_fins", fins, 1);
    check("busy_ignore_yo", first_yo, 1000);
    check("busy_ignore_idle", busy, 0);

    // Reset during the 10th DIV cycle aborts with no fin.
    @(negedge clk); x = 32'd12345678; y0 = 32'd100; req = 1'b1;
    @(posedge clk); #1; req = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); rstn = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_yo", yo, 0);
    check("abort_fin", fin, 0);
    check("abort_ovf", ovf, 0);
`ifdef SQRT_NEWTON_ITERCNT_EN
    check("abort_iter_cnt", iter_cnt, 0);
`endif
    @(negedge clk); rstn = 1'b1;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (fin || busy) got = 1;
    end
    check("abort_no_fin", got, 0);
    do_test(0, 32'd81, 32'd16);
    check("after_abort_yo", yo, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
